// File: rtl/prei_pkg.sv
// Shared definitions for the pre-intra mode buffer: widths, address-map bases,
// CU size encodings and the z-order mode address function.
package prei_pkg;

    localparam int MODE_W    = 6;
    localparam int ADDR_W    = 7;
    localparam int NUM_ENTRY = 85;

    localparam logic [ADDR_W-1:0] BASE8  = 7'd0;
    localparam logic [ADDR_W-1:0] BASE16 = 7'd64;
    localparam logic [ADDR_W-1:0] BASE32 = 7'd80;
    localparam logic [ADDR_W-1:0] BASE64 = 7'd84;

    typedef enum logic [1:0] {
        SZ8  = 2'd0,
        SZ16 = 2'd1,
        SZ32 = 2'd2,
        SZ64 = 2'd3
    } cu_size_e;

    // Position bits below the CU size are dropped so any 8x8 coordinate inside a CU hits it.
    function automatic logic [ADDR_W-1:0] mode_addr(input cu_size_e size,
                                                    input logic [2:0] x,
                                                    input logic [2:0] y);
        logic [ADDR_W-1:0] a;
        case (size)
            SZ8:     a = BASE8  + {1'b0, y[2], x[2], y[1], x[1], y[0], x[0]};
            SZ16:    a = BASE16 + {3'b000, y[2], x[2], y[1], x[1]};
            SZ32:    a = BASE32 + {5'b00000, y[2], x[2]};
            default: a = BASE64;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/prei_mode_bank.sv
// One ping-pong bank: 85 x MODE_W register array, one write port, one
// synchronously read port whose output register holds between reads.
module prei_mode_bank
    import prei_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [MODE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [MODE_W-1:0] rdata_o
);

    logic [MODE_W-1:0] mem_q [NUM_ENTRY];
    logic [MODE_W-1:0] rdata_d, rdata_q;

    // Array contents carry no reset; stale modes survive a short LCU by design.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prei_mode_buf.sv
// Ping-pong best-mode buffer between pre-intra mode decision (writer) and the
// intra/RDO stage (reader); bank ownership is tracked by full flags and pointers.
module prei_mode_buf
    import prei_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              md_we_i,
    input  logic [ADDR_W-1:0] md_waddr_i,
    input  logic [MODE_W-1:0] md_wdata_i,
    input  logic              md_finish_i,
    output logic              md_ready_o,
    output logic              lcu_vld_o,
    input  logic              rd_en_i,
    input  logic [1:0]        rd_size_i,
    input  logic [2:0]        rd_x_i,
    input  logic [2:0]        rd_y_i,
    output logic [MODE_W-1:0] rd_mode_o,
    output logic              rd_mode_vld_o,
    input  logic              rd_done_i,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] ENTRY_CNT = ADDR_W'(NUM_ENTRY);

    logic [1:0]        full_d, full_q;
    logic              wr_ptr_d, wr_ptr_q;
    logic              rd_ptr_d, rd_ptr_q;
    logic [ADDR_W-1:0] wr_cnt_d, wr_cnt_q;
    logic              err_d, err_q;
    logic              rd_vld_d, rd_vld_q;
    logic              rd_sel_d, rd_sel_q;

    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] raddr;
    logic [1:0]        bank_we, bank_re;
    logic [MODE_W-1:0] bank_rdata [2];

    assign raddr = mode_addr(cu_size_e'(rd_size_i), rd_x_i, rd_y_i);

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = 1'b0;

        wr_ok = md_we_i && !full_q[wr_ptr_q] && (md_waddr_i < ENTRY_CNT);
        if (md_we_i && !wr_ok) begin
            err_d = 1'b1;
        end

        // Saturate so an over-long LCU cannot wrap back to a "correct" count.
        cnt_inc = wr_cnt_q;
        if (wr_ok && (wr_cnt_q != '1)) begin
            cnt_inc = wr_cnt_q + 7'd1;
        end
        wr_cnt_d = cnt_inc;

        if (md_finish_i) begin
            if (full_q[wr_ptr_q]) begin
                err_d = 1'b1;
            end else begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
                wr_cnt_d         = '0;
                if (cnt_inc != ENTRY_CNT) begin
                    err_d = 1'b1;
                end
            end
        end

        // A legal finish needs an empty bank and a legal release a full one, so they never collide.
        if (rd_done_i && full_q[rd_ptr_q]) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end

        rd_ok    = rd_en_i && full_q[rd_ptr_q];
        rd_vld_d = rd_ok;
        rd_sel_d = rd_ok ? rd_ptr_q : rd_sel_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
            rd_vld_q <= rd_vld_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    always_comb begin
        bank_we = '0;
        bank_re = '0;
        bank_we[wr_ptr_q] = wr_ok;
        bank_re[rd_ptr_q] = rd_ok;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        prei_mode_bank u_bank (
            .clk     (clk),
            .rstn    (rstn),
            .we_i    (bank_we[b]),
            .waddr_i (md_waddr_i),
            .wdata_i (md_wdata_i),
            .re_i    (bank_re[b]),
            .raddr_i (raddr),
            .rdata_o (bank_rdata[b])
        );
    end

    // rd_sel_q only moves on a served read, so rd_mode_o holds across refused reads.
    assign rd_mode_o     = bank_rdata[rd_sel_q];
    assign rd_mode_vld_o = rd_vld_q;
    assign md_ready_o    = !full_q[wr_ptr_q];
    assign lcu_vld_o     = full_q[rd_ptr_q];
    assign err_o         = err_q;

endmodule

// File: tb/tb_prei_mode_buf.sv
// Directed bench for prei_mode_buf: full/short LCUs, size mapping, ping-pong
// stall, illegal writes, simultaneous finish/release and mid-LCU reset.
module tb_prei_mode_buf;

    logic       clk;
    logic       rstn;
    logic       md_we_i;
    logic [6:0] md_waddr_i;
    logic [5:0] md_wdata_i;
    logic       md_finish_i;
    logic       md_ready_o;
    logic       lcu_vld_o;
    logic       rd_en_i;
    logic [1:0] rd_size_i;
    logic [2:0] rd_x_i;
    logic [2:0] rd_y_i;
    logic [5:0] rd_mode_o;
    logic       rd_mode_vld_o;
    logic       rd_done_i;
    logic       err_o;

    int checks;
    int failures;

    prei_mode_buf dut (
        .clk           (clk),
        .rstn          (rstn),
        .md_we_i       (md_we_i),
        .md_waddr_i    (md_waddr_i),
        .md_wdata_i    (md_wdata_i),
        .md_finish_i   (md_finish_i),
        .md_ready_o    (md_ready_o),
        .lcu_vld_o     (lcu_vld_o),
        .rd_en_i       (rd_en_i),
        .rd_size_i     (rd_size_i),
        .rd_x_i        (rd_x_i),
        .rd_y_i        (rd_y_i),
        .rd_mode_o     (rd_mode_o),
        .rd_mode_vld_o (rd_mode_vld_o),
        .rd_done_i     (rd_done_i),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        md_we_i     = 1'b0;
        md_finish_i = 1'b0;
        rd_en_i     = 1'b0;
        rd_done_i   = 1'b0;
    endtask

    // Pattern 0: a%35, 1: 34-a%35, 2: (a+1)%35, 3: (2a)%35
    function automatic logic [5:0] pat(input int p, input int a);
        int v;
        case (p)
            0:       v = a % 35;
            1:       v = 34 - (a % 35);
            2:       v = (a + 1) % 35;
            default: v = (2 * a) % 35;
        endcase
        return 6'(v);
    endfunction

    // Writes addresses 0..n-1 with pattern p, one per cycle.
    task automatic write_lcu(input int p, input int n);
        for (int a = 0; a < n; a++) begin
            md_we_i    = 1'b1;
            md_waddr_i = 7'(a);
            md_wdata_i = pat(p, a);
            tick();
        end
        md_we_i = 1'b0;
    endtask

    task automatic finish_pulse();
        md_finish_i = 1'b1;
        tick();
        md_finish_i = 1'b0;
    endtask

    task automatic done_pulse();
        rd_done_i = 1'b1;
        tick();
        rd_done_i = 1'b0;
    endtask

    task automatic read_req(input logic [1:0] sz, input logic [2:0] x, input logic [2:0] y);
        rd_en_i   = 1'b1;
        rd_size_i = sz;
        rd_x_i    = x;
        rd_y_i    = y;
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        md_waddr_i = '0;
        md_wdata_i = '0;
        rd_size_i  = '0;
        rd_x_i     = '0;
        rd_y_i     = '0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if ({md_ready_o, lcu_vld_o, err_o, rd_mode_vld_o, rd_mode_o} !== {4'b1000, 6'd0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b err=%b mvld=%b mode=%0d, want 1 0 0 0 0",
                     md_ready_o, lcu_vld_o, err_o, rd_mode_vld_o, rd_mode_o);
        end
    endtask

    task automatic test_full_lcu();
        write_lcu(0, 85);
        finish_pulse();
        checks++;
        if ({err_o, md_ready_o, lcu_vld_o} !== 3'b011) begin
            failures++;
            $display("FAIL full_lcu_status: got err=%b rdy=%b vld=%b, want 0 1 1", err_o, md_ready_o, lcu_vld_o);
        end
        rd_en_i = 1'b1; rd_size_i = 2'd0; rd_x_i = 3'd3; rd_y_i = 3'd5;
        #1;
        checks++;
        if (rd_mode_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL full_lcu_latency: got mvld=%b before edge, want 0", rd_mode_vld_o);
        end
        tick();
        rd_en_i = 1'b0;
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd4}) begin
            failures++;
            $display("FAIL full_lcu_read39: got vld=%b mode=%0d, want 1 4", rd_mode_vld_o, rd_mode_o);
        end
        tick();
        checks++;
        if (rd_mode_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL full_lcu_vld_pulse: got mvld=%b, want 0", rd_mode_vld_o);
        end
    endtask

    task automatic test_size_map();
        // Back-to-back reads: addr 70 -> 0, addr 81 -> 11, addr 84 -> 14
        rd_en_i = 1'b1; rd_size_i = 2'd1; rd_x_i = 3'd5; rd_y_i = 3'd2;
        tick();
        rd_size_i = 2'd2; rd_x_i = 3'd7; rd_y_i = 3'd0;
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd0}) begin
            failures++;
            $display("FAIL size16_addr70: got vld=%b mode=%0d, want 1 0", rd_mode_vld_o, rd_mode_o);
        end
        tick();
        rd_size_i = 2'd3; rd_x_i = 3'd6; rd_y_i = 3'd1;
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd11}) begin
            failures++;
            $display("FAIL size32_addr81: got vld=%b mode=%0d, want 1 11", rd_mode_vld_o, rd_mode_o);
        end
        tick();
        rd_en_i = 1'b0;
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd14}) begin
            failures++;
            $display("FAIL size64_addr84: got vld=%b mode=%0d, want 1 14", rd_mode_vld_o, rd_mode_o);
        end
    endtask

    task automatic test_pingpong_stall();
        write_lcu(1, 85);
        finish_pulse();
        checks++;
        if ({err_o, md_ready_o, lcu_vld_o} !== 3'b001) begin
            failures++;
            $display("FAIL stall_both_full: got err=%b rdy=%b vld=%b, want 0 0 1", err_o, md_ready_o, lcu_vld_o);
        end
        finish_pulse();
        checks++;
        if ({err_o, md_ready_o, lcu_vld_o} !== 3'b101) begin
            failures++;
            $display("FAIL stall_third_finish: got err=%b rdy=%b vld=%b, want 1 0 1", err_o, md_ready_o, lcu_vld_o);
        end
        md_we_i = 1'b1; md_waddr_i = 7'd39; md_wdata_i = 6'd33;
        tick();
        md_we_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_write_err: got err=%b, want 1", err_o);
        end
        // Reader still owns LCU 1: the blocked write must not have landed anywhere
        read_req(2'd0, 3'd3, 3'd5);
        checks++;
        if ({err_o, rd_mode_vld_o, rd_mode_o} !== {2'b01, 6'd4}) begin
            failures++;
            $display("FAIL stall_bank0_intact: got err=%b vld=%b mode=%0d, want 0 1 4", err_o, rd_mode_vld_o, rd_mode_o);
        end
        done_pulse();
        checks++;
        if ({md_ready_o, lcu_vld_o} !== 2'b11) begin
            failures++;
            $display("FAIL stall_release: got rdy=%b vld=%b, want 1 1", md_ready_o, lcu_vld_o);
        end
        read_req(2'd0, 3'd3, 3'd5);
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd30}) begin
            failures++;
            $display("FAIL stall_second_lcu: got vld=%b mode=%0d, want 1 30", rd_mode_vld_o, rd_mode_o);
        end
    endtask

    task automatic test_short_lcu();
        write_lcu(2, 84);
        finish_pulse();
        checks++;
        if ({err_o, lcu_vld_o} !== 2'b11) begin
            failures++;
            $display("FAIL short_finish_err: got err=%b vld=%b, want 1 1", err_o, lcu_vld_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL short_err_pulse: got err=%b, want 0", err_o);
        end
        // Read and release in the same cycle: the read sees the bank being released (LCU 2)
        rd_done_i = 1'b1;
        read_req(2'd1, 3'd5, 3'd2);
        rd_done_i = 1'b0;
        checks++;
        if ({rd_mode_vld_o, rd_mode_o, lcu_vld_o} !== {1'b1, 6'd34, 1'b1}) begin
            failures++;
            $display("FAIL read_with_done: got vld=%b mode=%0d lcu=%b, want 1 34 1", rd_mode_vld_o, rd_mode_o, lcu_vld_o);
        end
        read_req(2'd0, 3'd3, 3'd5);
        checks++;
        if (rd_mode_o !== 6'd5) begin
            failures++;
            $display("FAIL short_written: got mode=%0d, want 5", rd_mode_o);
        end
        read_req(2'd3, 3'd0, 3'd0);
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd14}) begin
            failures++;
            $display("FAIL short_stale84: got vld=%b mode=%0d, want 1 14", rd_mode_vld_o, rd_mode_o);
        end
    endtask

    task automatic test_illegal_addr();
        md_we_i = 1'b1; md_waddr_i = 7'd100; md_wdata_i = 6'd7;
        tick();
        md_we_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL illegal_addr_err: got err=%b, want 1", err_o);
        end
        write_lcu(3, 85);
        finish_pulse();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL illegal_not_counted: got err=%b, want 0", err_o);
        end
        done_pulse();
        done_pulse();
        checks++;
        if ({md_ready_o, lcu_vld_o} !== 2'b10) begin
            failures++;
            $display("FAIL all_released: got rdy=%b vld=%b, want 1 0", md_ready_o, lcu_vld_o);
        end
        done_pulse();
        checks++;
        if ({err_o, md_ready_o, lcu_vld_o} !== 3'b010) begin
            failures++;
            $display("FAIL empty_done: got err=%b rdy=%b vld=%b, want 0 1 0", err_o, md_ready_o, lcu_vld_o);
        end
        // Last served read returned 14; a refused read must hold it
        read_req(2'd0, 3'd1, 3'd1);
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b0, 6'd14}) begin
            failures++;
            $display("FAIL read_when_empty: got vld=%b mode=%0d, want 0 14", rd_mode_vld_o, rd_mode_o);
        end
    endtask

    task automatic test_simul_and_reset();
        write_lcu(0, 85);
        finish_pulse();
        write_lcu(1, 85);
        md_finish_i = 1'b1;
        rd_done_i   = 1'b1;
        tick();
        idle();
        checks++;
        if ({err_o, md_ready_o, lcu_vld_o} !== 3'b011) begin
            failures++;
            $display("FAIL simul_status: got err=%b rdy=%b vld=%b, want 0 1 1", err_o, md_ready_o, lcu_vld_o);
        end
        // Reader now on bank 1 (pattern 1): addr 84 -> 34-14 = 20
        read_req(2'd3, 3'd0, 3'd0);
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd20}) begin
            failures++;
            $display("FAIL simul_read_bank1: got vld=%b mode=%0d, want 1 20", rd_mode_vld_o, rd_mode_o);
        end
        write_lcu(2, 10);
        md_we_i = 1'b1; md_waddr_i = 7'd10; md_wdata_i = 6'd1;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({md_ready_o, lcu_vld_o, err_o, rd_mode_vld_o} !== 4'b1000) begin
            failures++;
            $display("FAIL async_reset: got rdy=%b vld=%b err=%b mvld=%b, want 1 0 0 0",
                     md_ready_o, lcu_vld_o, err_o, rd_mode_vld_o);
        end
        idle();
        tick();
        rstn = 1'b1;
        tick();
        write_lcu(3, 85);
        finish_pulse();
        checks++;
        if ({err_o, md_ready_o, lcu_vld_o} !== 3'b011) begin
            failures++;
            $display("FAIL post_reset_lcu: got err=%b rdy=%b vld=%b, want 0 1 1", err_o, md_ready_o, lcu_vld_o);
        end
        read_req(2'd2, 3'd7, 3'd0);
        checks++;
        if ({rd_mode_vld_o, rd_mode_o} !== {1'b1, 6'd22}) begin
            failures++;
            $display("FAIL post_reset_read81: got vld=%b mode=%0d, want 1 22", rd_mode_vld_o, rd_mode_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_lcu();
        test_size_map();
        test_pingpong_stall();
        test_short_lcu();
        test_illegal_addr();
        test_simul_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
